reg_file_sb: RTL
================

# reg_file_sb

Parametrised general-purpose register file with integrated scoreboard, the successor to the single-write, dual-read 32×32 register array. It adds a configurable number of read ports, a hardwired-zero register, optional write-to-read bypass, and per-register busy tracking, so the pipelined core's issue stage can detect RAW/WAW hazards without a separate scoreboard. It sits between decode/issue (reads, destination claims) and writeback (writes, claim release).

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, if 1, register 0 reads as 0 and is never written or marked busy
- BYPASS, 1, if 1, a same-cycle write is forwarded to matching read ports

Ports:
- clk_Regs  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- Reg_Write  in  1  writeback strobe
- W_Addr  in  ADDR_W  writeback address
- W_Data  in  DATA_W  writeback data
- R_Addr  in  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- R_Data  out  NUM_RD*DATA_W  read data, combinational
- R_Busy  out  NUM_RD  per-port: addressed register has an outstanding claim
- Issue_Valid  in  1  issue stage requests a destination claim
- Issue_Addr  in  ADDR_W  destination register to claim
- Issue_Ready  out  1  claim accepted this cycle when Issue_Valid is high
- Busy_Cnt  out  ADDR_W+1  number of registers currently busy

## Operation
- Reset, asynchronous: all registers cleared to 0, all busy bits cleared, Busy_Cnt = 0, Issue_Ready = 1.
- Write: on posedge with Reg_Write = 1, REG[W_Addr] <= W_Data and busy[W_Addr] <= 0. With ZERO_REG = 1 and W_Addr = 0, the write is dropped.
- Write to a non-busy register is legal. It updates data; busy stays 0 and Busy_Cnt is unchanged.
- Read port i:
  - ZERO_REG and address 0: 0.
  - Otherwise, BYPASS and Reg_Write and W_Addr == R_Addr_i: W_Data.
  - Otherwise: REG[R_Addr_i].
- R_Busy[i] = busy[R_Addr_i], forced 0 when:
  - the address is 0 with ZERO_REG, or
  - BYPASS is set and the same-cycle write targets it.
- Claim:
  - Issue_Ready = !busy[Issue_Addr] || (Reg_Write && W_Addr == Issue_Addr). A WAW claim stalls until writeback, and writeback frees the claim in the same cycle.
  - Accepted claim (Issue_Valid && Issue_Ready) sets busy[Issue_Addr] at posedge.
  - Claim on register 0 with ZERO_REG: always ready, never sets busy.
- Simultaneous write and claim on the same address: the set wins. busy stays/ends 1, and the data is still written.
- Busy_Cnt update: +1 when an accepted claim sets a bit that was not already set after clear; −1 when a write clears a set bit that is not re-claimed. The net update is in {−1, 0, +1}. Busy_Cnt always equals the popcount of the busy bits.

## Timing
- Reads: zero latency, combinational from R_Addr, Reg_Write, W_Addr and W_Data.
- Write visible through the array on the cycle after the posedge; visible same cycle via bypass.
- Claim: busy visible on R_Busy the cycle after acceptance.
- Reset mid-operation: all claims are discarded immediately (asynchronous), with no pending write completion.
- Busy_Cnt is registered and updates at the same posedge as the busy bits.

## Structure
- Package rf_pkg: default DATA_W/ADDR_W/NUM_RD constants and a function for port-slice extraction.
- Sub-module rf_scoreboard holds the busy vector, Issue_Ready logic and Busy_Cnt counter. The top level holds the data array and read muxes/bypass.

## Test plan
- Reset → every R_Data = 0, R_Busy = 0, Busy_Cnt = 0, Issue_Ready = 1.
- Write x5 = 0xDEADBEEF with R_Addr0 = 5 in the same cycle:
  - BYPASS=1: R_Data0 = 0xDEADBEEF that cycle.
  - BYPASS=0: R_Data0 = 0 that cycle and 0xDEADBEEF the next.
- Write x0 = 0x1234 and claim x0 → R_Data on x0 stays 0, Issue_Ready = 1, Busy_Cnt stays 0.
- Claim x7 → R_Busy on x7 = 1 and Busy_Cnt = 1 next cycle. A second claim of x7 gives Issue_Ready = 0. Writing x7 in the same cycle as the second claim gives Issue_Ready = 1, x7 stays busy, and Busy_Cnt stays 1.
- Claim x1..x31 on consecutive cycles → Busy_Cnt = 31. Assert rst mid-sequence → Busy_Cnt = 0 and all R_Busy = 0 asynchronously.
- NUM_RD=4 with all ports reading distinct registers after random writes → each R_Data matches a reference model every cycle.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the register file and its scoreboard.
package rf_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_NUM_RD = 2;

  // Widest slice and packed bus the slice helper accepts.
  localparam int unsigned SLICE_MAX_W = 64;
  localparam int unsigned BUS_MAX_W   = 256;

  // Extracts field idx of width w from a packed multi-port bus.
  function automatic logic [SLICE_MAX_W-1:0] port_slice(
    input logic [BUS_MAX_W-1:0] bus,
    input int unsigned          idx,
    input int unsigned          w
  );
    logic [BUS_MAX_W-1:0] sh;
    sh = bus >> (idx * w);
    return sh[SLICE_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking: destination claims from issue, release on writeback.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                    clk_Regs,
  input  logic                    rst,
  input  logic                    Reg_Write,
  input  logic [ADDR_W-1:0]       W_Addr,
  input  logic                    Issue_Valid,
  input  logic [ADDR_W-1:0]       Issue_Addr,
  output logic [(2**ADDR_W)-1:0]  busy,
  output logic                    Issue_Ready,
  output logic [ADDR_W:0]         Busy_Cnt
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic             clr_en;
  logic             set_en;
  logic             zero_claim;
  logic             cnt_inc;
  logic             cnt_dec;
  logic [DEPTH-1:0] busy_nxt;

  assign clr_en     = Reg_Write && !(ZERO_REG && (W_Addr == '0));
  assign zero_claim = ZERO_REG && (Issue_Addr == '0);

  // A writeback to the claimed register frees it in the same cycle.
  assign Issue_Ready = zero_claim || !busy[Issue_Addr] ||
                       (Reg_Write && (W_Addr == Issue_Addr));
  assign set_en      = Issue_Valid && Issue_Ready && !zero_claim;

  // Set is applied after clear so a same-address claim keeps the bit high.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[W_Addr] = 1'b0;
    if (set_en) busy_nxt[Issue_Addr] = 1'b1;
  end

  assign cnt_inc = set_en && !busy[Issue_Addr];
  assign cnt_dec = clr_en && busy[W_Addr] && !(set_en && (Issue_Addr == W_Addr));

  always_ff @(posedge clk_Regs or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      Busy_Cnt <= '0;
    end else begin
      busy <= busy_nxt;
      if (cnt_inc && !cnt_dec) begin
        Busy_Cnt <= Busy_Cnt + CNT_ONE;
      end else if (cnt_dec && !cnt_inc) begin
        Busy_Cnt <= Busy_Cnt - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with optional zero register, write bypass and busy scoreboard.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_RD   = RF_NUM_RD,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                     clk_Regs,
  input  logic                     rst,
  input  logic                     Reg_Write,
  input  logic [ADDR_W-1:0]        W_Addr,
  input  logic [DATA_W-1:0]        W_Data,
  input  logic [NUM_RD*ADDR_W-1:0] R_Addr,
  output logic [NUM_RD*DATA_W-1:0] R_Data,
  output logic [NUM_RD-1:0]        R_Busy,
  input  logic                     Issue_Valid,
  input  logic [ADDR_W-1:0]        Issue_Addr,
  output logic                     Issue_Ready,
  output logic [ADDR_W:0]          Busy_Cnt
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_hit;

  assign wr_en = Reg_Write && !(ZERO_REG && (W_Addr == '0));

  always_ff @(posedge clk_Regs or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[W_Addr] <= W_Data;
    end
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk_Regs   (clk_Regs),
    .rst        (rst),
    .Reg_Write  (Reg_Write),
    .W_Addr     (W_Addr),
    .Issue_Valid(Issue_Valid),
    .Issue_Addr (Issue_Addr),
    .busy       (busy),
    .Issue_Ready(Issue_Ready),
    .Busy_Cnt   (Busy_Cnt)
  );

  // Zero register takes priority over bypass; a bypassed register reports not busy.
  always_comb begin
    R_Data  = '0;
    R_Busy  = '0;
    rd_addr = '0;
    rd_hit  = 1'b0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_addr = ADDR_W'(port_slice(BUS_MAX_W'(R_Addr), i, ADDR_W));
      rd_hit  = BYPASS && Reg_Write && (W_Addr == rd_addr);
      if (ZERO_REG && (rd_addr == '0)) begin
        R_Data[i*DATA_W +: DATA_W] = '0;
        R_Busy[i]                  = 1'b0;
      end else if (rd_hit) begin
        R_Data[i*DATA_W +: DATA_W] = W_Data;
        R_Busy[i]                  = 1'b0;
      end else begin
        R_Data[i*DATA_W +: DATA_W] = regs[rd_addr];
        R_Busy[i]                  = busy[rd_addr];
      end
    end
  end

endmodule
